// File: rtl/cnt_bus_arbiter_pkg.sv
// Shared definitions for the controller-BRAM (cnt_bus) arbiter and its requesters.
package cnt_bus_arbiter_pkg;

   localparam int CNT_ARB_NUM_REQ    = 5;
   localparam int CNT_ARB_ADDR_WIDTH = 8;
   localparam int CNT_ARB_DATA_WIDTH = 16;

   localparam int CNT_ARB_MOD      = 0;
   localparam int CNT_ARB_STM      = 1;
   localparam int CNT_ARB_SILENCER = 2;
   localparam int CNT_ARB_SYNC     = 3;
   localparam int CNT_ARB_DEBUG    = 4;

   typedef struct packed {
      logic                          we;
      logic [CNT_ARB_ADDR_WIDTH-1:0] addr;
      logic [CNT_ARB_DATA_WIDTH-1:0] din;
   } cnt_arb_req_t;

   // Next requester index after idx, wrapping at num.
   function automatic int cnt_arb_wrap_inc(input int idx, input int num);
      int nxt;
      nxt = idx + 1;
      if (nxt >= num) begin
         nxt = 0;
      end else begin
         nxt = idx + 1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/cnt_bus_arbiter_pick.sv
// Round-robin priority pick: first set request at or after ptr, wrapping at N.
module rr_priority_pick #(
   parameter int N  = 5,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic [IW-1:0] index,
   output logic          valid
);

   localparam int SW = IW + 1;

   // Walk candidates ptr, ptr+1, ... modulo N and keep the first requester found.
   always_comb begin
      logic [SW-1:0] cand_v;
      winner = '0;
      index  = '0;
      valid  = 1'b0;
      cand_v = '0;
      for (int k = 0; k < N; k++) begin
         cand_v = {1'b0, ptr} + SW'(k);
         if (cand_v >= SW'(N)) begin
            cand_v = cand_v - SW'(N);
         end else begin
            cand_v = {1'b0, ptr} + SW'(k);
         end
         if (!valid && req[cand_v[IW-1:0]]) begin
            winner[cand_v[IW-1:0]] = 1'b1;
            index                  = cand_v[IW-1:0];
            valid                  = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/cnt_bus_arbiter.sv
// Round-robin arbiter with optional burst lock sharing the controller BRAM port
// between the settings loaders; read data returns to the issuer at fixed latency.
module cnt_bus_arbiter
   import cnt_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = CNT_ARB_NUM_REQ,
   parameter int ADDR_WIDTH = CNT_ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH = CNT_ARB_DATA_WIDTH,
   parameter int RD_LATENCY = 2,
   parameter int MAX_BURST  = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ-1:0]            LOCK,
   input  logic [NUM_REQ-1:0]            WE,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] ADDR,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] DIN,
   output logic [NUM_REQ-1:0]            GNT,
   output logic [NUM_REQ-1:0]            RVALID,
   output logic [DATA_WIDTH-1:0]         RDATA,
   output logic                          BRAM_EN,
   output logic                          BRAM_WE,
   output logic [ADDR_WIDTH-1:0]         BRAM_ADDR,
   output logic [DATA_WIDTH-1:0]         BRAM_DIN,
   input  logic [DATA_WIDTH-1:0]         BRAM_DOUT
);

   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BURST_W = $clog2(MAX_BURST + 1);

   logic [PTR_W-1:0]      ptr_r;
   logic [PTR_W-1:0]      owner_r;
   logic                  owner_valid_r;
   logic [BURST_W-1:0]    burst_r;

   logic                  hold_s;
   logic [PTR_W-1:0]      pick_ptr_s;
   logic [NUM_REQ-1:0]    pick_winner_s;
   logic [PTR_W-1:0]      pick_index_s;
   logic                  pick_valid_s;
   logic [NUM_REQ-1:0]    gnt_s;
   logic [PTR_W-1:0]      gnt_idx_s;
   logic                  gnt_any_s;
   logic [BURST_W-1:0]    next_burst_s;
   cnt_arb_req_t          beat_s;

   logic                  bram_en_r;
   logic                  bram_we_r;
   logic [ADDR_WIDTH-1:0] bram_addr_r;
   logic [DATA_WIDTH-1:0] bram_din_r;

   logic [RD_LATENCY:0]   rd_pipe_r;
   logic [PTR_W-1:0]      id_pipe_r [RD_LATENCY+1];
   logic [NUM_REQ-1:0]    rvalid_oh_s;
   logic [NUM_REQ-1:0]    rvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;

   // Lock owner keeps the port while it still requests with LOCK and has budget left.
   always_comb begin
      hold_s = 1'b0;
      if (owner_valid_r && REQ[owner_r] && LOCK[owner_r] &&
          (burst_r < BURST_W'(MAX_BURST))) begin
         hold_s = 1'b1;
      end else begin
         hold_s = 1'b0;
      end
   end

   // While an owner is recorded, fair scanning restarts just after it.
   always_comb begin
      pick_ptr_s = ptr_r;
      if (owner_valid_r) begin
         pick_ptr_s = PTR_W'(cnt_arb_wrap_inc(int'(owner_r), NUM_REQ));
      end else begin
         pick_ptr_s = ptr_r;
      end
   end

   rr_priority_pick #(
      .N  (NUM_REQ),
      .IW (PTR_W)
   ) u_pick (
      .req    (REQ),
      .ptr    (pick_ptr_s),
      .winner (pick_winner_s),
      .index  (pick_index_s),
      .valid  (pick_valid_s)
   );

   // Beat accept: lock hold beats round-robin; nothing granted while in reset.
   always_comb begin
      gnt_s     = '0;
      gnt_idx_s = '0;
      gnt_any_s = 1'b0;
      if (RST) begin
         gnt_any_s = 1'b0;
      end else if (hold_s) begin
         gnt_s[owner_r] = 1'b1;
         gnt_idx_s      = owner_r;
         gnt_any_s      = 1'b1;
      end else begin
         gnt_s     = pick_winner_s;
         gnt_idx_s = pick_index_s;
         gnt_any_s = pick_valid_s;
      end
   end

   assign GNT = gnt_s;

   // Selected requester's beat and the burst count it would reach.
   always_comb begin
      beat_s.we   = WE[gnt_idx_s];
      beat_s.addr = ADDR[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      beat_s.din  = DIN[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      if (owner_valid_r && (owner_r == gnt_idx_s)) begin
         next_burst_s = burst_r + 1'b1;
      end else begin
         next_burst_s = BURST_W'(1);
      end
   end

   // Pointer, lock owner and burst count bookkeeping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr_r         <= '0;
         owner_r       <= '0;
         owner_valid_r <= 1'b0;
         burst_r       <= '0;
      end else if (gnt_any_s) begin
         if (LOCK[gnt_idx_s] && (next_burst_s != BURST_W'(MAX_BURST))) begin
            owner_valid_r <= 1'b1;
            owner_r       <= gnt_idx_s;
            burst_r       <= next_burst_s;
         end else begin
            // Unlocked beat or exhausted burst: release and rotate past this requester.
            owner_valid_r <= 1'b0;
            burst_r       <= '0;
            ptr_r         <= PTR_W'(cnt_arb_wrap_inc(int'(gnt_idx_s), NUM_REQ));
         end
      end else if (owner_valid_r && !hold_s) begin
         owner_valid_r <= 1'b0;
         burst_r       <= '0;
         ptr_r         <= PTR_W'(cnt_arb_wrap_inc(int'(owner_r), NUM_REQ));
      end else begin
         burst_r <= burst_r;
      end
   end

   // Issue register: the accepted beat drives the BRAM port one cycle later.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bram_en_r   <= 1'b0;
         bram_we_r   <= 1'b0;
         bram_addr_r <= '0;
         bram_din_r  <= '0;
      end else if (gnt_any_s) begin
         bram_en_r   <= 1'b1;
         bram_we_r   <= beat_s.we;
         bram_addr_r <= beat_s.addr;
         bram_din_r  <= beat_s.din;
      end else begin
         bram_en_r   <= 1'b0;
         bram_we_r   <= 1'b0;
      end
   end

   assign BRAM_EN   = bram_en_r;
   assign BRAM_WE   = bram_we_r;
   assign BRAM_ADDR = bram_addr_r;
   assign BRAM_DIN  = bram_din_r;

   // Return tracker: read flag and issuer ID travel alongside the BRAM access.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_pipe_r <= '0;
         for (int k = 0; k <= RD_LATENCY; k++) begin
            id_pipe_r[k] <= '0;
         end
      end else begin
         rd_pipe_r    <= {rd_pipe_r[RD_LATENCY-1:0], gnt_any_s & ~beat_s.we};
         id_pipe_r[0] <= gnt_idx_s;
         for (int k = 1; k <= RD_LATENCY; k++) begin
            id_pipe_r[k] <= id_pipe_r[k-1];
         end
      end
   end

   // One-hot of the requester whose read data is on BRAM_DOUT now.
   always_comb begin
      rvalid_oh_s = '0;
      if (rd_pipe_r[RD_LATENCY]) begin
         rvalid_oh_s[id_pipe_r[RD_LATENCY]] = 1'b1;
      end else begin
         rvalid_oh_s = '0;
      end
   end

   // Registered read return; RDATA keeps its last value between returns.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rvalid_r <= '0;
         rdata_r  <= '0;
      end else if (rd_pipe_r[RD_LATENCY]) begin
         rvalid_r <= rvalid_oh_s;
         rdata_r  <= BRAM_DOUT;
      end else begin
         rvalid_r <= '0;
      end
   end

   assign RVALID = rvalid_r;
   assign RDATA  = rdata_r;

endmodule

// File: tb/tb_cnt_bus_arbiter.sv
// Self-checking bench for cnt_bus_arbiter: vector tables for grant order, a BRAM
// model, and a scoreboard of expected read returns with their due cycle.
module tb_cnt_bus_arbiter;
   import cnt_bus_arbiter_pkg::*;

   localparam int NR  = CNT_ARB_NUM_REQ;
   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int LAT = 2;
   localparam int MB  = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic [NR-1:0] REQ, LOCK, WE;
   logic [NR*AW-1:0] ADDR;
   logic [NR*DW-1:0] DIN;
   logic [NR-1:0] GNT, RVALID;
   logic [DW-1:0] RDATA;
   logic          BRAM_EN, BRAM_WE;
   logic [AW-1:0] BRAM_ADDR;
   logic [DW-1:0] BRAM_DIN, BRAM_DOUT;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   cnt_bus_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .MAX_BURST(MB)
   ) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .WE(WE), .ADDR(ADDR), .DIN(DIN),
      .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
      .BRAM_ADDR(BRAM_ADDR), .BRAM_DIN(BRAM_DIN), .BRAM_DOUT(BRAM_DOUT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Preloaded contents of every address that has not been written.
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      if (a == 8'h10) return 16'hBEEF;
      return {a ^ 8'h5A, a};
   endfunction

   // Write-first BRAM with LAT-cycle read latency.
   logic [DW-1:0] mem [256];
   logic [255:0]  mem_wr = '0;
   logic [DW-1:0] dpipe [LAT];
   always @(posedge CLK) begin
      if (BRAM_EN) begin
         if (BRAM_WE) begin
            mem[BRAM_ADDR]    <= BRAM_DIN;
            mem_wr[BRAM_ADDR] <= 1'b1;
            dpipe[0]          <= BRAM_DIN;
         end else begin
            dpipe[0] <= mem_wr[BRAM_ADDR] ? mem[BRAM_ADDR] : pat(BRAM_ADDR);
         end
      end
      for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
   end
   assign BRAM_DOUT = dpipe[LAT-1];

   // Bench-side shadow of the memory contents it expects.
   logic [DW-1:0] ref_mem [256];
   bit            ref_wr  [256];
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      return ref_wr[a] ? ref_mem[a] : pat(a);
   endfunction

   typedef struct {
      int            id;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t exp_q[$];

   // Scoreboard: each expected return must appear exactly in its due cycle.
   always @(negedge CLK) begin
      logic [NR-1:0] oh;
      if (!RST) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            oh = '0;
            oh[exp_q[0].id] = 1'b1;
            checks++;
            if (RVALID !== oh || RDATA !== exp_q[0].data) begin
               failures++;
               $display("FAIL rd_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                        cyc, RVALID, RDATA, oh, exp_q[0].data);
            end
            void'(exp_q.pop_front());
         end else if (RVALID !== '0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid cyc=%0d got rvalid=%b want 0", cyc, RVALID);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic set_idle();
      REQ = '0; LOCK = '0; WE = '0; ADDR = '0; DIN = '0;
   endtask

   // Drive one beat at a negedge, check GNT, record expected effects, advance.
   task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] lock,
                       input logic [NR-1:0] we, input logic [NR*AW-1:0] addr,
                       input logic [NR*DW-1:0] din, input logic [NR-1:0] exp_gnt,
                       input string name);
      logic [AW-1:0] a;
      exp_t e;
      REQ = req; LOCK = lock; WE = we; ADDR = addr; DIN = din;
      #1;
      check(name, 32'(GNT), 32'(exp_gnt));
      for (int i = 0; i < NR; i++) begin
         if (exp_gnt[i]) begin
            a = addr[i*AW +: AW];
            if (we[i]) begin
               ref_mem[a] = din[i*DW +: DW];
               ref_wr[a]  = 1'b1;
            end else begin
               e.id = i; e.data = exp_rd(a); e.due = cyc + 2 + LAT;
               exp_q.push_back(e);
            end
         end
      end
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step('0, '0, '0, '0, '0, '0, "idle_gnt");
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},    32'(GNT), 32'h0);
      check({tag, "_rvalid"}, 32'(RVALID), 32'h0);
      check({tag, "_bram_en"}, 32'(BRAM_EN), 32'h0);
      check({tag, "_bram_we"}, 32'(BRAM_WE), 32'h0);
      check({tag, "_rdata"},  32'(RDATA), 32'h0);
      check({tag, "_bram_addr"}, 32'(BRAM_ADDR), 32'h0);
      check({tag, "_bram_din"}, 32'(BRAM_DIN), 32'h0);
   endtask

   task automatic do_reset();
      set_idle();
      RST = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   typedef struct {
      logic [NR-1:0]    req, lock, we;
      logic [NR*AW-1:0] addr;
      logic [NR*DW-1:0] din;
      logic [NR-1:0]    gnt;
   } vec_t;
   vec_t tbl[$];

   task automatic run_table(input string name);
      foreach (tbl[r]) step(tbl[r].req, tbl[r].lock, tbl[r].we, tbl[r].addr, tbl[r].din,
                            tbl[r].gnt, name);
      tbl.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got timeout want completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [NR*AW-1:0] av;
      logic [NR-1:0]    rq, ex;
      int n1;

      // Reset values
      set_idle();
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      check_all_zero("reset");
      RST = 1'b0;
      @(negedge CLK);

      // Single read from silencer: grant now, BRAM access next cycle, data four later
      av = '0;
      av[CNT_ARB_SILENCER*AW +: AW] = 8'h10;
      step(5'b00100, '0, '0, av, '0, 5'b00100, "t1_gnt");
      check("t1_bram_en", 32'(BRAM_EN), 32'h1);
      check("t1_bram_we", 32'(BRAM_WE), 32'h0);
      check("t1_bram_addr", 32'(BRAM_ADDR), 32'h10);
      idle(6);
      check("t1_rdata_hold", 32'(RDATA), 32'hBEEF);

      // All five requesters, unlocked: strict rotation from pointer 0
      do_reset();
      for (int k = 0; k < 10; k++) begin
         v.req = 5'h1F; v.lock = '0; v.we = '0; v.din = '0; v.addr = '0;
         for (int i = 0; i < NR; i++)
            v.addr[i*AW +: AW] = AW'(32'h40 + 8*i + k/5 + ((i < k%5) ? 1 : 0));
         v.gnt = '0;
         v.gnt[k%5] = 1'b1;
         tbl.push_back(v);
      end
      run_table("rot_gnt");
      idle(6);

      // Locked 4-word burst by sync while mod waits
      for (int k = 0; k < 5; k++) begin
         v.we = '0; v.din = '0; v.addr = '0;
         v.addr[CNT_ARB_SYNC*AW +: AW] = AW'(32'h20 + k);
         v.addr[CNT_ARB_MOD*AW +: AW]  = 8'h50;
         v.req  = (k == 0) ? 5'b01000 : (k < 4) ? 5'b01001 : 5'b00001;
         v.lock = (k < 4) ? 5'b01000 : 5'b00000;
         v.gnt  = (k < 4) ? 5'b01000 : 5'b00001;
         tbl.push_back(v);
      end
      run_table("lock_gnt");
      idle(6);

      // Burst limit: 16 locked beats for stm, then debug once, then stm again
      do_reset();
      n1 = 0;
      for (int s = 0; s <= 40; s++) begin
         rq = 5'b00010;
         if (s <= 16) rq[CNT_ARB_DEBUG] = 1'b1;
         ex = (s == 16) ? 5'b10000 : 5'b00010;
         av = '0;
         av[CNT_ARB_STM*AW +: AW]   = AW'(32'h80 + n1);
         av[CNT_ARB_DEBUG*AW +: AW] = 8'hC0;
         step(rq, 5'b00010, '0, av, '0, ex, "burst_gnt");
         if (ex[CNT_ARB_STM]) n1++;
      end
      idle(6);

      // Write then read the same address on back-to-back beats
      av = '0;
      av[CNT_ARB_SILENCER*AW +: AW] = 8'h05;
      step(5'b00100, '0, 5'b00100, av, {16'h0, 16'h0, 16'h1234, 16'h0, 16'h0}, 5'b00100, "wr_gnt");
      check("wr_bram_en", 32'(BRAM_EN), 32'h1);
      check("wr_bram_we", 32'(BRAM_WE), 32'h1);
      check("wr_bram_addr", 32'(BRAM_ADDR), 32'h05);
      check("wr_bram_din", 32'(BRAM_DIN), 32'h1234);
      step(5'b00100, '0, '0, av, '0, 5'b00100, "rd_gnt");
      check("rd_bram_en", 32'(BRAM_EN), 32'h1);
      check("rd_bram_we", 32'(BRAM_WE), 32'h0);
      idle(6);

      // Reset with two reads in flight
      av = '0;
      av[CNT_ARB_MOD*AW +: AW] = 8'h30;
      step(5'b00001, '0, '0, av, '0, 5'b00001, "rst_rd0_gnt");
      av[CNT_ARB_MOD*AW +: AW] = 8'h31;
      step(5'b00001, '0, '0, av, '0, 5'b00001, "rst_rd1_gnt");
      REQ = 5'h1F;
      RST = 1'b1;
      exp_q.delete();
      #1;
      check_all_zero("midrst");
      @(negedge CLK);
      RST = 1'b0;
      set_idle();
      for (int j = 0; j < 6; j++) begin
         check("post_rst_rvalid", 32'(RVALID), 32'h0);
         @(negedge CLK);
      end
      av = '0;
      for (int i = 0; i < NR; i++) av[i*AW +: AW] = AW'(32'h70 + i);
      step(5'h1F, '0, '0, av, '0, 5'b00001, "post_rst_ptr");
      idle(6);

      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cnt_bus_arbiter.md
Name: cnt_bus_arbiter

Overview:
Shares the single controller-BRAM port (cnt_bus side) between NUM_REQ settings loaders (mod, stm, silencer, sync, debug).
- Round-robin grant, one beat accepted per cycle.
- Optional LOCK holds the grant, so multi-word fields (e.g. 64-bit TRANSITION_VALUE, ECAT_SYNC_TIME) are read back-to-back and coherently.
- Read data returns to the issuing requester with a fixed latency.
- Sits between the controller's per-settings loaders and the memory module's controller BRAM port.

Parameters:
- NUM_REQ, 5: number of requesters (index 0 = mod, 1 = stm, 2 = silencer, 3 = sync, 4 = debug).
- ADDR_WIDTH, 8: controller BRAM word address width.
- DATA_WIDTH, 16: BRAM word width.
- RD_LATENCY, 2: BRAM read latency in cycles; range 1..4.
- MAX_BURST, 16: maximum consecutive locked grants before forced rotation.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- REQ  in  NUM_REQ  request valid, one bit per requester.
- LOCK  in  NUM_REQ  hold grant while asserted with REQ.
- WE  in  NUM_REQ  1 = write beat, 0 = read beat.
- ADDR  in  NUM_REQ x ADDR_WIDTH  per-requester word address.
- DIN  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- GNT  out  NUM_REQ  combinational beat-accept, one-hot or zero.
- RVALID  out  NUM_REQ  registered read-data valid, one-hot or zero.
- RDATA  out  DATA_WIDTH  registered read data, shared by all requesters.
- BRAM_EN  out  1  registered BRAM enable.
- BRAM_WE  out  1  registered BRAM write enable.
- BRAM_ADDR  out  ADDR_WIDTH  registered BRAM address.
- BRAM_DIN  out  DATA_WIDTH  registered BRAM write data.
- BRAM_DOUT  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after BRAM_EN.

Behaviour:
- Reset:
  - GNT, RVALID, BRAM_EN, BRAM_WE = 0; RDATA, BRAM_ADDR, BRAM_DIN = 0.
  - Priority pointer = 0; burst counter = 0; lock owner = none.
  - Return pipeline cleared.
- Handshake:
  - Valid/ready style. Requester holds REQ/WE/ADDR/DIN/LOCK stable until it sees GNT[i]=1 at a rising edge.
  - At that edge the beat is accepted; the requester may present the next beat or drop REQ.
- Grant selection (combinational from registered state):
  - If a lock owner is set, REQ[owner]=1, LOCK[owner]=1 and burst count < MAX_BURST: GNT[owner]=1.
  - Otherwise the first REQ[i] scanning from pointer upward with wrap gets GNT[i]=1.
  - No REQ: GNT=0.
- State update on each accepted beat for requester i:
  - If LOCK[i]=1: owner = i; burst count +1.
  - If LOCK[i]=0: owner cleared; burst count = 0; pointer = (i+1) mod NUM_REQ.
  - Owner drops REQ or LOCK: owner cleared, burst count = 0, pointer = owner+1.
  - Burst count reaches MAX_BURST: owner cleared, count = 0, pointer = owner+1. Any competing requester is then granted before the former owner.
- Issue latency: beat accepted in cycle t drives BRAM_EN=1, BRAM_WE, BRAM_ADDR, BRAM_DIN in cycle t+1. With no accept, BRAM_EN=0 and BRAM_WE=0.
- Read return:
  - The requester ID and read flag ride a RD_LATENCY+1 deep shift register.
  - RVALID[i]=1 and RDATA=BRAM_DOUT are registered in cycle t+2+RD_LATENCY (t+4 at default).
  - Returns are in issue order. Writes produce no RVALID.
  - RDATA holds its last value when RVALID=0.
- Throughput: one beat per cycle sustained, across requesters or within a locked burst.
- Simultaneous events:
  - All REQ high, none locked: grants rotate 0,1,2,3,4,0,...
  - Read to an address in the cycle after a write to the same address returns the new data (BRAM write-first is required of the memory).
- Reset mid-operation: in-flight returns are discarded; no RVALID after reset deassertion until a new read is issued.

Decomposition:
- Shared package (params): CNT_ARB_NUM_REQ, requester index constants (CNT_ARB_MOD=0 ... CNT_ARB_DEBUG=4), and typedef cnt_arb_req_t {we, addr, din}.
- Sub-module rr_priority_pick: combinational; inputs request vector and pointer; outputs one-hot winner and index. Reused by future arbiters.
- Return shift register stays inline.

Test Plan:
- Reset, then REQ[2]=1 read ADDR=0x10, BRAM preloaded 0xBEEF: GNT[2] in cycle 0, BRAM_EN/ADDR=0x10 in cycle 1, RVALID[2]=1 with RDATA=0xBEEF in cycle 4, no other RVALID.
- All five requesters issue unlocked reads simultaneously and continuously for 10 beats: GNT order 0,1,2,3,4,0,1,2,3,4; each RVALID carries its own address's data.
- REQ[3]+LOCK[3] reads 4 words 0x20..0x23 while REQ[0] is pending: 4 consecutive GNT[3] beats, then GNT[0]; RDATA order is 0x20..0x23 then requester 0's data.
- LOCK held on requester 1 for 40 beats with REQ[4] pending, MAX_BURST=16: GNT[1] ×16, then GNT[4] ×1, then GNT[1] resumes.
- Write 0x1234 to 0x05 then read 0x05 from the same requester on back-to-back beats: BRAM_WE=1 then 0; RVALID data = 0x1234; no RVALID for the write.
- RST asserted with 2 reads in flight: all outputs 0 immediately; no RVALID in the 6 cycles after release; pointer restarts at 0.
